// File: rtl/if_stage_if.sv
// Instruction SRAM request/response bus between the fetch stage and the instruction memory.
// The fetch stage is the master: it raises requests and receives acceptance and read data.
interface if_stage_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    modport master (
        output inst_req,
        output inst_addr,
        input  inst_addr_ok,
        input  inst_data_ok,
        input  inst_rdata
    );

    modport slave (
        input  inst_req,
        input  inst_addr,
        output inst_addr_ok,
        output inst_data_ok,
        output inst_rdata
    );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: one-outstanding SRAM fetch FSM, delay-slot-aware redirect latch,
// exception flush with stale-response drop, and the IF/ID pipeline register.
module if_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallD,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        exc_valid,
    input  logic [31:0] exc_pc,
    if_stage_if.master  imem,
    output logic [31:0] instrD,
    output logic [31:0] pcD,
    output logic        validD,
    output logic        adelD
);
    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_HOLD,
        ST_DROP
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] pcf_reg, pcf_next;
    logic        pend_valid_reg, pend_valid_next;
    logic [31:0] pend_pc_reg, pend_pc_next;
    logic [31:0] hold_reg, hold_next;
    logic        req_reg, req_next;
    logic [31:0] instr_reg, instr_next;
    logic [31:0] pcd_reg, pcd_next;
    logic        valid_reg, valid_next;
    logic        adel_reg, adel_next;
    logic        advance;
    logic        misaligned;

    assign misaligned = (pcf_reg[1:0] != 2'b00);

    always_comb begin
        state_next      = state_reg;
        pcf_next        = pcf_reg;
        pend_valid_next = pend_valid_reg;
        pend_pc_next    = pend_pc_reg;
        hold_next       = hold_reg;
        instr_next      = instr_reg;
        pcd_next        = pcd_reg;
        valid_next      = valid_reg;
        adel_next       = adel_reg;
        advance         = 1'b0;

        if (exc_valid) begin
            // Flush overrides stall and redirect; an accepted request still owes a response.
            pcf_next        = exc_pc;
            pend_valid_next = 1'b0;
            hold_next       = 32'd0;
            instr_next      = 32'd0;
            valid_next      = 1'b0;
            adel_next       = 1'b0;
            if ((state_reg == ST_WAIT && !imem.inst_data_ok) ||
                (state_reg == ST_REQ && req_reg && imem.inst_addr_ok))
                state_next = ST_DROP;
            else
                state_next = ST_REQ;
        end else begin
            if (!stallD) begin
                instr_next = 32'd0;
                valid_next = 1'b0;
                adel_next  = 1'b0;
            end
            unique case (state_reg)
                ST_IDLE: state_next = ST_REQ;
                ST_REQ: begin
                    if (misaligned) begin
                        if (!stallD) begin
                            instr_next = 32'd0;
                            pcd_next   = pcf_reg;
                            valid_next = 1'b1;
                            adel_next  = 1'b1;
                            advance    = 1'b1;
                        end
                    end else if (imem.inst_addr_ok) begin
                        state_next = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem.inst_data_ok) begin
                        if (!stallD) begin
                            instr_next = imem.inst_rdata;
                            pcd_next   = pcf_reg;
                            valid_next = 1'b1;
                            adel_next  = 1'b0;
                            advance    = 1'b1;
                            state_next = ST_REQ;
                        end else begin
                            hold_next  = imem.inst_rdata;
                            state_next = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!stallD) begin
                        instr_next = hold_reg;
                        pcd_next   = pcf_reg;
                        valid_next = 1'b1;
                        adel_next  = 1'b0;
                        advance    = 1'b1;
                        state_next = ST_REQ;
                    end
                end
                ST_DROP: begin
                    if (imem.inst_data_ok)
                        state_next = ST_REQ;
                end
                default: state_next = ST_IDLE;
            endcase

            // The instruction being delivered is the delay slot; a redirect targets the fetch after it.
            if (advance) begin
                if (redirect_valid)
                    pcf_next = redirect_pc;
                else if (pend_valid_reg)
                    pcf_next = pend_pc_reg;
                else
                    pcf_next = pcf_reg + 32'd4;
                pend_valid_next = 1'b0;
            end else if (redirect_valid) begin
                pend_valid_next = 1'b1;
                pend_pc_next    = redirect_pc;
            end
        end

        req_next = (state_next == ST_REQ) && (pcf_next[1:0] == 2'b00);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            pcf_reg        <= RESET_PC;
            pend_valid_reg <= 1'b0;
            pend_pc_reg    <= 32'd0;
            hold_reg       <= 32'd0;
            req_reg        <= 1'b0;
            instr_reg      <= 32'd0;
            pcd_reg        <= 32'd0;
            valid_reg      <= 1'b0;
            adel_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            pcf_reg        <= pcf_next;
            pend_valid_reg <= pend_valid_next;
            pend_pc_reg    <= pend_pc_next;
            hold_reg       <= hold_next;
            req_reg        <= req_next;
            instr_reg      <= instr_next;
            pcd_reg        <= pcd_next;
            valid_reg      <= valid_next;
            adel_reg       <= adel_next;
        end
    end

    assign imem.inst_req  = req_reg;
    assign imem.inst_addr = pcf_reg;
    assign instrD         = instr_reg;
    assign pcD            = pcd_reg;
    assign validD         = valid_reg;
    assign adelD          = adel_reg;
endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios then random stall/redirect/exception traffic against an
// instruction-stream model (expected next PC plus pending redirect) and a latency-randomised SRAM.
module tb_if_stage;
    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallD, redirect_valid, exc_valid;
    logic [31:0] redirect_pc, exc_pc;
    logic [31:0] instrD, pcD;
    logic        validD, adelD;

    if_stage_if bus ();

    if_stage dut (
        .clk            (clk),
        .rst            (rst),
        .stallD         (stallD),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .exc_valid      (exc_valid),
        .exc_pc         (exc_pc),
        .imem           (bus),
        .instrD         (instrD),
        .pcD            (pcD),
        .validD         (validD),
        .adelD          (adelD)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned n_del = 0;
    logic [31:0] del_q[$];

    // Instruction-stream model: next PC expected in IF/ID and a pending redirect target.
    logic [31:0] exp_pc;
    logic        pend;
    logic [31:0] pend_pc;

    // SRAM model state and knobs.
    int unsigned ok_pct, lat_min, lat_max;
    logic        sram_busy;
    int          sram_cnt;
    logic [31:0] sram_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic sram_update(input logic acc, input logic dok, input logic [31:0] a);
        if (dok) sram_busy = 1'b0;
        if (acc) begin
            sram_busy = 1'b1;
            sram_addr = a;
            sram_cnt  = int'($urandom_range(lat_max, lat_min));
        end
        bus.inst_data_ok = 1'b0;
        bus.inst_rdata   = $urandom;
        if (sram_busy) begin
            sram_cnt--;
            if (sram_cnt == 0) begin
                bus.inst_data_ok = 1'b1;
                bus.inst_rdata   = mem_word(sram_addr);
            end
        end
        bus.inst_addr_ok = !sram_busy && ($urandom_range(99, 0) < ok_pct);
    endtask

    task automatic step(input logic s, input logic rv, input logic [31:0] rp,
                        input logic ev, input logic [31:0] ep);
        logic        acc, dok, p_valid, p_adel, deliv;
        logic [31:0] a_pre, p_instr, p_pc;
        stallD = s; redirect_valid = rv; redirect_pc = rp; exc_valid = ev; exc_pc = ep;
        if (bus.inst_req === 1'b1) chk("inst_addr", bus.inst_addr, exp_pc);
        if (exp_pc[1:0] != 2'b00) chk("req_misaligned", {31'd0, bus.inst_req}, 32'd0);
        acc = bus.inst_req && bus.inst_addr_ok;
        dok = bus.inst_data_ok;
        a_pre = bus.inst_addr;
        p_instr = instrD; p_pc = pcD; p_valid = validD; p_adel = adelD;
        deliv = 1'b0;
        @(posedge clk); #1;
        if (ev) begin
            chk("exc_valid", {31'd0, validD}, 32'd0);
            chk("exc_instr", instrD, 32'd0);
            chk("exc_adel", {31'd0, adelD}, 32'd0);
            chk("exc_pcD", pcD, p_pc);
            exp_pc = ep;
            pend = 1'b0;
        end else if (s) begin
            chk("stall_instr", instrD, p_instr);
            chk("stall_pcD", pcD, p_pc);
            chk("stall_valid", {31'd0, validD}, {31'd0, p_valid});
            chk("stall_adel", {31'd0, adelD}, {31'd0, p_adel});
        end else if (validD === 1'b1) begin
            deliv = 1'b1;
            n_del++;
            del_q.push_back(pcD);
            chk("del_pcD", pcD, exp_pc);
            chk("del_adel", {31'd0, adelD}, {31'd0, exp_pc[1:0] != 2'b00});
            chk("del_instr", instrD, (exp_pc[1:0] != 2'b00) ? 32'd0 : mem_word(exp_pc));
        end else begin
            chk("bub_instr", instrD, 32'd0);
            chk("bub_adel", {31'd0, adelD}, 32'd0);
            chk("bub_pcD", pcD, p_pc);
        end
        if (!ev) begin
            if (deliv) begin
                exp_pc = rv ? rp : (pend ? pend_pc : exp_pc + 32'd4);
                pend = 1'b0;
            end else if (rv) begin
                pend = 1'b1;
                pend_pc = rp;
            end
        end
        sram_update(acc, dok, a_pre);
    endtask

    task automatic do_reset();
        logic dok;
        dok = bus.inst_data_ok;
        rst = 1'b1; stallD = 1'b0; redirect_valid = 1'b0; exc_valid = 1'b0;
        #1;
        chk("rst_req", {31'd0, bus.inst_req}, 32'd0);
        chk("rst_instr", instrD, 32'd0);
        chk("rst_pcD", pcD, 32'd0);
        chk("rst_valid", {31'd0, validD}, 32'd0);
        chk("rst_adel", {31'd0, adelD}, 32'd0);
        @(posedge clk); #1;
        sram_update(1'b0, dok, 32'd0);
        rst = 1'b0;
        exp_pc = RESET_PC;
        pend = 1'b0;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    endtask

    initial begin
        int unsigned base;
        rst = 1'b1; stallD = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        exc_valid = 1'b0; exc_pc = '0;
        bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b0; bus.inst_rdata = '0;
        sram_busy = 1'b0; sram_cnt = 0; sram_addr = '0;
        ok_pct = 100; lat_min = 1; lat_max = 1;
        exp_pc = RESET_PC; pend = 1'b0; pend_pc = '0;

        // Reset, then the first two sequential fetches.
        do_reset();
        for (int i = 0; i < 20 && bus.inst_req !== 1'b1; i++) idle();
        chk("first_addr", bus.inst_addr, RESET_PC);
        for (int i = 0; i < 40 && n_del < 2; i++) idle();
        chk("first_two", {31'd0, n_del >= 2}, 32'd1);
        chk("seq0", del_q[0], RESET_PC);
        chk("seq1", del_q[1], RESET_PC + 32'd4);

        // Stall across the response: data parks in the hold buffer, then delivers on release.
        for (int i = 0; i < 20 && !(bus.inst_req && bus.inst_addr_ok); i++) idle();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
        base = n_del;
        idle();
        chk("hold_release", n_del, base + 1);
        chk("hold_pc", del_q[$], RESET_PC + 32'd8);

        // Branch at 0x10 resolves while the delay slot is in flight.
        for (int i = 0; i < 40 && del_q[$] != RESET_PC + 32'h10; i++) idle();
        chk("beq_seen", del_q[$], RESET_PC + 32'h10);
        step(1'b0, 1'b1, RESET_PC + 32'h100, 1'b0, 32'd0);
        base = n_del;
        for (int i = 0; i < 40 && n_del < base + 2; i++) idle();
        chk("delay_slot", del_q[$-1], RESET_PC + 32'h14);
        chk("target", del_q[$], RESET_PC + 32'h100);

        // Exception while waiting on a slow response: stale data must be dropped.
        lat_min = 3; lat_max = 3;
        for (int i = 0; i < 20 && !(bus.inst_req && bus.inst_addr_ok); i++) idle();
        idle();
        step(1'b0, 1'b0, 32'd0, 1'b1, RESET_PC + 32'h380);
        base = n_del;
        for (int i = 0; i < 40 && n_del == base; i++) idle();
        chk("exc_target", del_q[$], RESET_PC + 32'h380);

        // Misaligned redirect target raises an address error without a request.
        lat_min = 1; lat_max = 1;
        step(1'b0, 1'b1, RESET_PC + 32'h102, 1'b0, 32'd0);
        for (int i = 0; i < 40 && del_q[$] != RESET_PC + 32'h102; i++) idle();
        chk("adel_pcD", pcD, RESET_PC + 32'h102);
        chk("adel_flag", {31'd0, adelD}, 32'd1);
        chk("adel_valid", {31'd0, validD}, 32'd1);
        chk("adel_instr", instrD, 32'd0);

        // Exception, stall and data_ok in one cycle: exception wins.
        step(1'b0, 1'b0, 32'd0, 1'b1, RESET_PC + 32'h200);
        for (int i = 0; i < 20 && bus.inst_data_ok !== 1'b1; i++) idle();
        step(1'b1, 1'b0, 32'd0, 1'b1, RESET_PC + 32'h380);
        base = n_del;
        for (int i = 0; i < 40 && n_del == base; i++) idle();
        chk("exc_stall_target", del_q[$], RESET_PC + 32'h380);

        // Reset in the middle of an outstanding request; its late response is ignored.
        lat_min = 3; lat_max = 3;
        for (int i = 0; i < 20 && !(bus.inst_req && bus.inst_addr_ok); i++) idle();
        idle();
        do_reset();
        base = n_del;
        for (int i = 0; i < 40 && n_del < base + 2; i++) idle();
        chk("rst_mid0", del_q[$-1], RESET_PC);
        chk("rst_mid1", del_q[$], RESET_PC + 32'd4);

        // Random traffic.
        ok_pct = 70; lat_min = 1; lat_max = 3;
        base = n_del;
        for (int i = 0; i < 3000; i++) begin
            logic        s, rv, ev;
            logic [31:0] rp, ep;
            s  = ($urandom_range(99, 0) < 25);
            rv = ($urandom_range(99, 0) < 5);
            ev = ($urandom_range(99, 0) < 2);
            rp = RESET_PC | ($urandom_range(1023, 0) << 2);
            if ($urandom_range(99, 0) < 10) rp[1] = 1'b1;
            ep = RESET_PC | ($urandom_range(255, 0) << 2);
            step(s, rv, rp, ev, ep);
        end
        chk("liveness", {31'd0, n_del > base + 200}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
